ex_mem_pipe: RTL
================

// Module: ex_mem_pipe
// PURPOSE
// - EX->MEM pipeline register, next generation: parametrised widths, stall/flush control,
//   HI/LO write fields, load/store fields, and a hold-over path for multi-cycle EX ops.
// - Sits between the execute stage and the memory-access stage.
// - Consumes the ctrl stall vector and flush; feeds the MEM stage and the EX multi-cycle loop.
// PARAMETERS
// - DW      32  data/address width (wdata, hi, lo, mem_addr, reg2)
// - AW       5  register-file address width
// - OPW      8  aluop width passed to MEM
// - CNTW     2  multi-cycle step counter width
// - STALL_W  6  stall vector width
// - EX_IDX   3  stall bit owned by EX
// - MEM_IDX  4  stall bit owned by MEM
// PORTS
// - clk             in   1        clock, all state on rising edge
// - rst             in   1        synchronous reset, active-high (`RstEnable)
// - stall           in   STALL_W  per-stage stall request from ctrl
// - flush           in   1        exception/redirect flush
// - ex_wd           in   AW       destination register
// - ex_wreg         in   1        register write enable
// - ex_wdata        in   DW       register write data
// - ex_whilo        in   1        HI/LO write enable
// - ex_hi, ex_lo    in   DW each  HI/LO write data
// - ex_aluop        in   OPW      op code for the MEM stage
// - ex_mem_addr     in   DW       load/store effective address
// - ex_reg2         in   DW       store data
// - hilo_i          in   2*DW     partial result from EX multi-cycle op
// - cnt_i           in   CNTW     EX multi-cycle step count
// - mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2
//                   out  as input registered copies of the ex_* fields
// - hilo_o          out  2*DW     held partial result returned to EX
// - cnt_o           out  CNTW     held step count returned to EX
// BEHAVIOUR
// - Single always @(posedge clk) block. Every output is a register with no combinational path.
// - Reset (rst==1, synchronous): mem_wd=`NOPRegAddr; mem_wreg=mem_whilo=`WriteDisable;
//   aluop=`EXE_NOP_OP; all data outputs and hilo_o are 0; cnt_o=0. Reset overrides flush and stall.
// - Priority, evaluated each edge: rst > flush > bubble > hold > advance.
// - flush=1: same values as reset (all fields cleared), independent of stall.
// - Bubble (stall[EX_IDX]=1, stall[MEM_IDX]=0):
//   - Load NOP into all mem_* fields.
//   - hilo_o<=hilo_i and cnt_o<=cnt_i (multi-cycle op keeps progressing).
// - Hold (stall[EX_IDX]=1, stall[MEM_IDX]=1):
//   - All mem_* fields keep their values.
//   - hilo_o/cnt_o still capture hilo_i/cnt_i.
// - Advance (stall[EX_IDX]=0):
//   - Every mem_* field <= its ex_* input.
//   - hilo_o<=0, cnt_o<=0 (loop cleared once the op leaves EX).
// - stall[EX_IDX]=0 with stall[MEM_IDX]=1 is illegal from ctrl. The block treats it as Advance;
//   the bench asserts it never occurs.
// - Latency: exactly one cycle ex_* -> mem_* when advancing; zero bubbles inserted otherwise.
// - Widths: no arithmetic; fields are copied bit-exact, zero-filled only on reset, flush or bubble.
// STRUCTURE
// - Shared defines: `RstEnable, `WriteDisable, `NOPRegAddr, `ZeroWord, `EXE_NOP_OP,
//   stall index constants.
// - No sub-module. The NOP/clear value is a single local task/function used by reset, flush
//   and bubble.
// TESTING
// - Reset: rst=1 with ex_wdata=32'hFFFF_FFFF, ex_wreg=1
//     -> next edge mem_wdata=0, mem_wreg=0, mem_wd=0, cnt_o=0.
// - Advance: stall=0, ex_wd=5'd8, ex_wdata=32'h1234_5678, ex_whilo=1, ex_hi=32'hA
//     -> one edge later mem_* equal the inputs.
// - Bubble: stall=6'b001111 -> mem_wreg=0, mem_aluop=NOP; cnt_i=2'b01 gives cnt_o=2'b01,
//   and hilo_o=hilo_i.
// - Hold: stall=6'b011111 for 3 cycles with changing ex_* -> mem_* frozen at pre-stall values;
//   cnt_o tracks cnt_i.
// - Flush: flush=1 during Hold -> all cleared next edge. rst=1 together with flush=1 gives
//   the same result.
// - Release: stall drops to 0 after madd hold-over -> mem_* take ex_*; hilo_o=0, cnt_o=0.

Source files
------------

// File: rtl/ex_mem_pipe_pkg.sv
// Shared constants and control decode for the EX->MEM pipeline register.
package ex_mem_pipe_pkg;

  localparam logic        RstEnable    = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [4:0]  NopRegAddr   = 5'b00000;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [7:0]  ExeNopOp     = 8'h00;

  localparam int unsigned StallExIdx  = 3;
  localparam int unsigned StallMemIdx = 4;

  typedef enum logic [1:0] {
    ModeFlush,
    ModeBubble,
    ModeHold,
    ModeAdvance
  } pipe_mode_e;

  // EX stalled alone inserts a bubble; EX and MEM stalled together freezes the stage.
  // MEM stalled without EX cannot come from ctrl and falls through to advance.
  function automatic pipe_mode_e decode_mode(input logic flush, input logic stall_ex,
                                             input logic stall_mem);
    if (flush)                  return ModeFlush;
    if (stall_ex && !stall_mem) return ModeBubble;
    if (stall_ex && stall_mem)  return ModeHold;
    return ModeAdvance;
  endfunction

endpackage

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with stall/flush control and a hold-over loop that
// returns the partial result of a multi-cycle EX operation.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned OPW     = 8,
  parameter int unsigned CNTW    = 2,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned EX_IDX  = StallExIdx,
  parameter int unsigned MEM_IDX = StallMemIdx
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [AW-1:0]      ex_wd,
  input  logic               ex_wreg,
  input  logic [DW-1:0]      ex_wdata,
  input  logic               ex_whilo,
  input  logic [DW-1:0]      ex_hi,
  input  logic [DW-1:0]      ex_lo,
  input  logic [OPW-1:0]     ex_aluop,
  input  logic [DW-1:0]      ex_mem_addr,
  input  logic [DW-1:0]      ex_reg2,
  input  logic [2*DW-1:0]    hilo_i,
  input  logic [CNTW-1:0]    cnt_i,
  output logic [AW-1:0]      mem_wd,
  output logic               mem_wreg,
  output logic [DW-1:0]      mem_wdata,
  output logic               mem_whilo,
  output logic [DW-1:0]      mem_hi,
  output logic [DW-1:0]      mem_lo,
  output logic [OPW-1:0]     mem_aluop,
  output logic [DW-1:0]      mem_mem_addr,
  output logic [DW-1:0]      mem_reg2,
  output logic [2*DW-1:0]    hilo_o,
  output logic [CNTW-1:0]    cnt_o
);

  typedef struct packed {
    logic [AW-1:0]  wd;
    logic           wreg;
    logic [DW-1:0]  wdata;
    logic           whilo;
    logic [DW-1:0]  hi;
    logic [DW-1:0]  lo;
    logic [OPW-1:0] aluop;
    logic [DW-1:0]  mem_addr;
    logic [DW-1:0]  reg2;
  } stage_t;

  // The one NOP image shared by reset, flush and bubble.
  function automatic stage_t nop_stage();
    stage_t s;
    s          = '0;
    s.wd       = AW'(NopRegAddr);
    s.wreg     = WriteDisable;
    s.wdata    = DW'(ZeroWord);
    s.whilo    = WriteDisable;
    s.hi       = DW'(ZeroWord);
    s.lo       = DW'(ZeroWord);
    s.aluop    = OPW'(ExeNopOp);
    s.mem_addr = DW'(ZeroWord);
    s.reg2     = DW'(ZeroWord);
    return s;
  endfunction

  stage_t          ex_s, mem_q, mem_d;
  logic [2*DW-1:0] hilo_q, hilo_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  pipe_mode_e      mode;

  logic unused_stall;
  assign unused_stall = ^stall;

  assign ex_s = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, whilo: ex_whilo, hi: ex_hi,
                  lo: ex_lo, aluop: ex_aluop, mem_addr: ex_mem_addr, reg2: ex_reg2};

  assign mode = decode_mode(flush, stall[EX_IDX], stall[MEM_IDX]);

  always_comb begin
    mem_d  = mem_q;
    hilo_d = hilo_q;
    cnt_d  = cnt_q;
    unique case (mode)
      ModeFlush: begin
        mem_d  = nop_stage();
        hilo_d = '0;
        cnt_d  = '0;
      end
      ModeBubble: begin
        mem_d  = nop_stage();
        hilo_d = hilo_i;
        cnt_d  = cnt_i;
      end
      ModeHold: begin
        hilo_d = hilo_i;
        cnt_d  = cnt_i;
      end
      ModeAdvance: begin
        mem_d  = ex_s;
        hilo_d = '0;
        cnt_d  = '0;
      end
      default: begin
        mem_d  = nop_stage();
        hilo_d = '0;
        cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      mem_q  <= nop_stage();
      hilo_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      hilo_q <= hilo_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mem_wd       = mem_q.wd;
  assign mem_wreg     = mem_q.wreg;
  assign mem_wdata    = mem_q.wdata;
  assign mem_whilo    = mem_q.whilo;
  assign mem_hi       = mem_q.hi;
  assign mem_lo       = mem_q.lo;
  assign mem_aluop    = mem_q.aluop;
  assign mem_mem_addr = mem_q.mem_addr;
  assign mem_reg2     = mem_q.reg2;
  assign hilo_o       = hilo_q;
  assign cnt_o        = cnt_q;

endmodule
